load_align_unit: RTL

Registered, variable-latency load back-end between the data-memory port and the MEM/WB stage of the MIPS pipeline. It accepts one load request at a time, detects misaligned accesses (AdEL), and drives a memory read until the memory acknowledges or a timeout expires. It then aligns, sign/zero-extends or merges (LWL/LWR) the returned word and holds the result under a valid/ready handshake. Byte-lane ordering and bus timeout are set by parameters.

---
 rtl/load_align_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/load_align_unit.sv
// Load back-end between the data-memory port and MEM/WB: misalignment check,
// bus read with timeout, then byte/half/word extraction and LWL/LWR merge.
module load_align_unit #(
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [1:0]  req_ofs,
  input  logic [31:0] req_rt,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        exc_adel,
  output logic        exc_bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam bit               TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

  state_t           state, state_nx;
  logic [2:0]       type_q;
  logic [1:0]       ofs_q;
  logic [31:0]      rt_q;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             valid_nx, adel_nx, bus_nx, capture;
  logic [31:0]      data_nx, aligned, shifted;
  logic [1:0]       lane;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             misaligned;

  // Held low during reset so the pipeline sees no ready until reset is released.
  assign req_ready = rst_n && (state == IDLE);
  assign mem_rd    = (state == WAIT);

  assign misaligned = ((req_type == 3'd0 || req_type == 3'd7) && req_ofs != 2'd0) ||
                      ((req_type == 3'd3 || req_type == 3'd4) && req_ofs[0]);

  assign lane     = BIG_ENDIAN ? (ofs_q ^ 2'd3) : ofs_q;
  assign shifted  = mem_rdata >> {lane, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    aligned = mem_rdata;
    case (type_q)
      3'd1: aligned = {{24{byte_sel[7]}}, byte_sel};
      3'd2: aligned = {24'd0, byte_sel};
      3'd3: aligned = {{16{half_sel[15]}}, half_sel};
      3'd4: aligned = {16'd0, half_sel};
      3'd5: begin
        case (lane)
          2'd0:    aligned = {mem_rdata[7:0],  rt_q[23:0]};
          2'd1:    aligned = {mem_rdata[15:0], rt_q[15:0]};
          2'd2:    aligned = {mem_rdata[23:0], rt_q[7:0]};
          default: aligned = mem_rdata;
        endcase
      end
      3'd6: begin
        case (lane)
          2'd0:    aligned = mem_rdata;
          2'd1:    aligned = {rt_q[31:24], mem_rdata[31:8]};
          2'd2:    aligned = {rt_q[31:16], mem_rdata[31:16]};
          default: aligned = {rt_q[31:8],  mem_rdata[31:24]};
        endcase
      end
      default: aligned = mem_rdata;
    endcase
  end

  // An ack in the final timeout cycle takes precedence over the bus error.
  always_comb begin
    state_nx = state;
    valid_nx = out_valid;
    data_nx  = out_data;
    adel_nx  = exc_adel;
    bus_nx   = exc_bus;
    cnt_nx   = cnt;
    capture  = 1'b0;
    if (flush) begin
      state_nx = IDLE;
      valid_nx = 1'b0;
      adel_nx  = 1'b0;
      bus_nx   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            capture = 1'b1;
            if (misaligned) begin
              state_nx = DONE;
              valid_nx = 1'b1;
              adel_nx  = 1'b1;
              bus_nx   = 1'b0;
              data_nx  = 32'd0;
            end else begin
              state_nx = WAIT;
              cnt_nx   = '0;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state_nx = DONE;
            valid_nx = 1'b1;
            adel_nx  = 1'b0;
            bus_nx   = 1'b0;
            data_nx  = aligned;
          end else if (TO_EN && cnt == LAST) begin
            state_nx = DONE;
            valid_nx = 1'b1;
            adel_nx  = 1'b0;
            bus_nx   = 1'b1;
            data_nx  = 32'd0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            adel_nx  = 1'b0;
            bus_nx   = 1'b0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      exc_adel  <= 1'b0;
      exc_bus   <= 1'b0;
      cnt       <= '0;
      type_q    <= 3'd0;
      ofs_q     <= 2'd0;
      rt_q      <= 32'd0;
    end else begin
      state     <= state_nx;
      out_valid <= valid_nx;
      out_data  <= data_nx;
      exc_adel  <= adel_nx;
      exc_bus   <= bus_nx;
      cnt       <= cnt_nx;
      if (capture) begin
        type_q <= req_type;
        ofs_q  <= req_ofs;
        rt_q   <= req_rt;
      end
    end
  end

endmodule
